// File: rtl/mix_pkg.sv
// Shared definitions for the mixed CPU / block-I/O memory scheduler.
package mix_pkg;
    localparam int WORD_W          = 31;   // sign bit 30, five 6-bit bytes
    localparam int MIX_AW          = 12;   // 4096-word memory
    localparam int MIX_BLOCK_WORDS = 100;  // default words per block transfer

    typedef enum logic [2:0] {
        IDLE,
        IN_WAIT,
        IN_WR,
        OUT_RD,
        OUT_LAT,
        OUT_SEND,
        DONE
    } state_e;
endpackage

// File: rtl/mix_port_arb.sv
// Single memory port arbiter: CPU versus block-I/O engine.
// Optional macro MIX_IO_FAIR_EN: after a contested cycle won by the CPU, the
// I/O engine wins the next contested cycle (I/O waits at most one cycle).
// Without it the CPU has strict priority and I/O may starve.
module mix_port_arb
    import mix_pkg::*;
#(
    parameter int AW = MIX_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [AW-1:0]     io_addr,
    input  logic [WORD_W-1:0] io_wdata,
    output logic              cpu_gnt,
    output logic              io_gnt,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata
);
    // Nothing is granted while reset is held, so an aborted transfer cannot write.
    logic cpu_rq, io_rq;
    assign cpu_rq = cpu_req & ~reset;
    assign io_rq  = io_req  & ~reset;

`ifdef MIX_IO_FAIR_EN
    logic owe_q, owe_d;

    // owe_q marks that the CPU won the last contested cycle; I/O takes the next one.
    always_comb begin
        io_gnt  = io_rq & (~cpu_rq | owe_q);
        cpu_gnt = cpu_rq & ~io_gnt;
        owe_d   = owe_q;
        if (cpu_rq && io_rq) begin
            owe_d = cpu_gnt;
        end
    end

    // Fairness token register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owe_q <= 1'b0;
        end else begin
            owe_q <= owe_d;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;
    assign cpu_gnt    = cpu_rq;
    assign io_gnt     = io_rq & ~cpu_rq;
`endif

    // Port mux: granted requester drives the port; idle port shows the CPU address.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        if (io_gnt) begin
            mem_addr  = io_addr;
            mem_we    = io_we;
            mem_wdata = io_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end
endmodule

// File: rtl/mix_io_sched.sv
// Block I/O sequencer sharing one synchronous-RAM port with a CPU.
// IN blocks move device words into memory, OUT blocks stream memory to the
// device; addresses wrap modulo 2^AW. Optional macro MIX_IO_FAIR_EN (see
// mix_port_arb) bounds I/O starvation under CPU traffic.
module mix_io_sched
    import mix_pkg::*;
#(
    parameter int BLOCK_WORDS = MIX_BLOCK_WORDS,
    parameter int AW          = MIX_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    input  logic              io_start,
    input  logic              io_dir,
    input  logic [AW-1:0]     io_base,
    output logic              io_busy,
    output logic              io_done,
    input  logic              din_valid,
    input  logic [WORD_W-1:0] din_data,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [WORD_W-1:0] dout_data,
    input  logic              dout_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);
    localparam int             CW   = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BLOCK_WORDS - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     base_q, base_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              io_req, io_we, io_gnt;
    logic [AW-1:0]     io_addr;

    assign io_req  = (state_q == IN_WR) || (state_q == OUT_RD);
    assign io_we   = (state_q == IN_WR);
    assign io_addr = base_q + AW'(cnt_q);

    mix_port_arb #(.AW(AW)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (hold_q),
        .cpu_gnt   (cpu_gnt),
        .io_gnt    (io_gnt),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata)
    );

    // Status outputs are forced low while reset is held.
    assign io_busy    = (state_q != IDLE)     & ~reset;
    assign io_done    = (state_q == DONE)     & ~reset;
    assign din_ready  = (state_q == IN_WAIT)  & ~reset;
    assign dout_valid = (state_q == OUT_SEND) & ~reset;
    assign dout_data  = dout_q;

    // Next-state logic: block sequencing, word index and data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        hold_d  = hold_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (io_start) begin
                    state_d = io_dir ? OUT_RD : IN_WAIT;
                    base_d  = io_base;
                    cnt_d   = '0;
                end
            end
            IN_WAIT: begin
                if (din_valid) begin
                    hold_d  = din_data;
                    state_d = IN_WR;
                end
            end
            IN_WR: begin
                if (io_gnt) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = IN_WAIT;
                    end
                end
            end
            OUT_RD: begin
                if (io_gnt) begin
                    state_d = OUT_LAT;
                end
            end
            OUT_LAT: begin
                // RAM data for the address issued in OUT_RD is valid now.
                dout_d  = mem_rdata;
                state_d = OUT_SEND;
            end
            OUT_SEND: begin
                if (dout_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = OUT_RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            hold_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_mix_io_sched.sv
// Self-checking bench for mix_io_sched with a 4-word block and a RAM model.
module tb_mix_io_sched;
    import mix_pkg::*;

    localparam int NW = 4;
    localparam int AW = 12;

    typedef struct {
        logic [AW-1:0]     a;
        logic [WORD_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we, cpu_gnt;
    logic [AW-1:0]     cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              io_start, io_dir, io_busy, io_done;
    logic [AW-1:0]     io_base;
    logic              din_valid, din_ready, dout_valid, dout_ready;
    logic [WORD_W-1:0] din_data, dout_data;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;

    logic [WORD_W-1:0] mem [0:4095];
    wr_t               wq[$];
    logic [WORD_W-1:0] rq[$];
    int                n_chk = 0;
    int                n_err = 0;
    int                done_cnt = 0;
    int                d0;

    always #5 clk = ~clk;

    mix_io_sched #(.BLOCK_WORDS(NW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt),
        .io_start(io_start), .io_dir(io_dir), .io_base(io_base),
        .io_busy(io_busy), .io_done(io_done),
        .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
        .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous RAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard side: I/O writes, OUT handshakes and done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_we && !cpu_gnt) begin
                if (wq.size() == 0) begin
                    chk("io_wr_unexp", wq.size(), 1);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("io_wr_addr", mem_addr, e.a);
                    chk("io_wr_data", mem_wdata, e.d);
                end
            end
            if (dout_valid && dout_ready) begin
                if (rq.size() == 0) begin
                    chk("dout_unexp", rq.size(), 1);
                end else begin
                    chk("dout_data", dout_data, rq.pop_front());
                end
            end
            if (io_done) done_cnt++;
        end
    end

    task automatic cpu_write(input logic [AW-1:0] a, input logic [WORD_W-1:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        smp();
        chk("cpu_wr_gnt", cpu_gnt, 1);
        chk("cpu_wr_addr", mem_addr, a);
        tick();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic io_go(input logic dir, input logic [AW-1:0] base);
        io_start = 1'b1; io_dir = dir; io_base = base;
        tick();
        io_start = 1'b0; io_base = base ^ 12'h555;
    endtask

    // Enter at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic feed(input logic [WORD_W-1:0] w);
        int t = 0;
        din_valid = 1'b1; din_data = w;
        smp();
        while (!din_ready && t < 100) begin
            tick(); smp(); t++;
        end
        chk("din_ready", din_ready, 1);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int t = 0;
        smp();
        while (!io_done && t < limit) begin
            tick(); smp(); t++;
        end
        chk("io_done_seen", io_done, 1);
        chk("busy_in_done", io_busy, 1);
        tick(); smp();
        chk("busy_after_done", io_busy, 0);
        chk("done_one_cycle", io_done, 0);
        tick();
    endtask

    task automatic wait_dout(input logic [WORD_W-1:0] exp);
        int t = 0;
        smp();
        while (!dout_valid && t < 50) begin
            tick(); smp(); t++;
        end
        chk("dout_valid", dout_valid, 1);
        chk("dout_first", dout_data, exp);
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_wdata = '0;
        io_start = 1'b0; io_dir = 1'b0; io_base = '0;
        din_valid = 1'b0; din_data = '0; dout_ready = 1'b0;

        // Reset state (CPU request held to show the grant is masked).
        repeat (3) tick();
        smp();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", io_busy, 0);
        chk("rst_done", io_done, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_data", dout_data, 0);
        tick();
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'd123;
        tick();

        // Idle port shows the CPU address with no write.
        smp();
        chk("idle_addr", mem_addr, 123);
        chk("idle_we", mem_we, 0);
        tick();

        // IN block at 10: words 1..4.
        d0 = done_cnt;
        io_go(1'b0, 12'd10);
        smp();
        chk("in_busy", io_busy, 1);
        chk("in_wait", din_ready, 1);
        tick();
        for (int i = 0; i < NW; i++) begin
            wq.push_back('{a: AW'(10 + i), d: WORD_W'(i + 1)});
            feed(WORD_W'(i + 1));
        end
        wait_done(50);
        chk("in_done_cnt", done_cnt - d0, 1);
        for (int i = 0; i < NW; i++) chk("in_mem", mem[10 + i], i + 1);

        // OUT block across the top of memory, started together with a CPU request.
        cpu_write(12'd4094, 31'h1111_0001);
        cpu_write(12'd4095, 31'h2222_0002);
        cpu_write(12'd0,    31'h3333_0003);
        cpu_write(12'd1,    31'h0444_0004);
        rq.push_back(31'h1111_0001); rq.push_back(31'h2222_0002);
        rq.push_back(31'h3333_0003); rq.push_back(31'h0444_0004);
        d0 = done_cnt;
        dout_ready = 1'b0;
        cpu_req = 1'b1; cpu_addr = 12'd5;
        io_start = 1'b1; io_dir = 1'b1; io_base = 12'd4094;
        smp();
        chk("start_cpu_gnt", cpu_gnt, 1);
        chk("start_cpu_rd_we", mem_we, 0);
        tick();
        cpu_req = 1'b0; io_start = 1'b0; io_base = 12'h123;
        smp();
        chk("out_busy", io_busy, 1);
        wait_dout(31'h1111_0001);
        repeat (3) begin
            tick(); smp();
            chk("dout_hold_valid", dout_valid, 1);
            chk("dout_hold_data", dout_data, 31'h1111_0001);
        end
        dout_ready = 1'b1;
        wait_done(100);
        dout_ready = 1'b0;
        chk("out_done_cnt", done_cnt - d0, 1);
        chk("out_rq_empty", rq.size(), 0);

        // io_start during a busy IN block is ignored.
        d0 = done_cnt;
        io_go(1'b0, 12'd20);
        for (int i = 0; i < NW; i++) begin
            wq.push_back('{a: AW'(20 + i), d: WORD_W'(12'h100 + i)});
            feed(WORD_W'(12'h100 + i));
            if (i == 0) begin
                io_start = 1'b1; io_dir = 1'b1; io_base = 12'd700;
                tick();
                io_start = 1'b0;
            end
        end
        wait_done(50);
        chk("busy_start_done_cnt", done_cnt - d0, 1);
        chk("busy_start_mem", mem[20], 31'h100);

        // CPU holding the port during an IN block.
        d0 = done_cnt;
        io_go(1'b0, 12'd40);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd7;
        wq.push_back('{a: 12'd40, d: 31'h200});
        feed(31'h200);
`ifdef MIX_IO_FAIR_EN
        smp();
        chk("fair_cpu_first", cpu_gnt, 1);
        chk("fair_no_wr", mem_we, 0);
        tick(); smp();
        chk("fair_io_second", cpu_gnt, 0);
        chk("fair_io_wr", mem_we, 1);
        chk("fair_io_addr", mem_addr, 40);
        tick();
        for (int i = 1; i < NW; i++) begin
            wq.push_back('{a: AW'(40 + i), d: WORD_W'(12'h200 + i)});
            feed(WORD_W'(12'h200 + i));
        end
        wait_done(50);
        cpu_req = 1'b0;
`else
        repeat (8) begin
            smp();
            chk("starve_busy", io_busy, 1);
            chk("starve_cpu_gnt", cpu_gnt, 1);
            chk("starve_din_ready", din_ready, 0);
            tick();
        end
        chk("starve_no_wr", wq.size(), 1);
        cpu_req = 1'b0;
        tick();
        for (int i = 1; i < NW; i++) begin
            wq.push_back('{a: AW'(40 + i), d: WORD_W'(12'h200 + i)});
            feed(WORD_W'(12'h200 + i));
        end
        wait_done(50);
`endif
        chk("cont_done_cnt", done_cnt - d0, 1);
        chk("cont_mem_last", mem[43], 31'h203);

        // Reset while in OUT_SEND aborts the block.
        cpu_write(12'd100, 31'h3AB);
        d0 = done_cnt;
        dout_ready = 1'b0;
        io_go(1'b1, 12'd100);
        wait_dout(31'h3AB);
        reset = 1'b1;
        #1;
        chk("rst_mid_dout_valid", dout_valid, 0);
        tick();
        reset = 1'b0; dout_ready = 1'b1;
        smp();
        chk("abort_busy", io_busy, 0);
        chk("abort_dout_valid", dout_valid, 0);
        chk("abort_dout_data", dout_data, 0);
        repeat (6) tick();
        chk("abort_no_done", done_cnt - d0, 0);
        dout_ready = 1'b0;

        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach the end (errors so far %0d)", n_err);
        $fatal(1);
    end
endmodule
